// File: rtl/prog_flash_pkg.sv
// Shared types for the parametrised program-flash controller: SPM command
// encodings, controller FSM states, counter width and section helper.
package prog_flash_pkg;

    typedef enum logic [2:0] {
        BUF_FILL   = 3'd1,
        CHIP_ERASE = 3'd2,
        PAGE_ERASE = 3'd3,
        PAGE_WRITE = 3'd5,
        RWW_EN     = 3'd7
    } spm_cmd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERASE  = 3'd1,
        WRITE  = 3'd2,
        CERASE = 3'd3,
        DONE   = 3'd4
    } flash_state_t;

    // Wide enough for any realistic erase/write cycle count.
    localparam int CNT_W = 16;

    // True when a page index lies in the read-while-write section.
    function automatic logic in_rww(input logic [31:0] page, input logic [31:0] nrww_start);
        return (page < nrww_start);
    endfunction

endpackage

// File: rtl/prog_page_buffer.sv
// SPM page buffer: PAGE_WORDS x WORD_W words plus a per-word fill mask.
// The first fill of a word after a clear wins; later fills to the same word
// are dropped. Unfilled words read as all-ones so a page write leaves the
// corresponding flash bits untouched.
module prog_page_buffer #(
    parameter int  WORD_W     = 16,
    parameter int  PAGE_WORDS = 64,
    localparam int PW         = $clog2(PAGE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         fill_en,
    input  logic [PW-1:0]                fill_idx,
    input  logic [WORD_W-1:0]            fill_data,
    output logic [PAGE_WORDS*WORD_W-1:0] data_all
);

    logic [WORD_W-1:0]     word_r [PAGE_WORDS];
    logic [PAGE_WORDS-1:0] mask_r;

    // Buffer storage: reset/clear to erased state, otherwise accept first fill per word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mask_r <= {PAGE_WORDS{1'b0}};
            for (int i = 0; i < PAGE_WORDS; i++) begin
                word_r[i] <= {WORD_W{1'b1}};
            end
        end else if (fill_en && !mask_r[fill_idx]) begin
            word_r[fill_idx] <= fill_data;
            mask_r[fill_idx] <= 1'b1;
        end
    end

    // Present the whole page in one flat vector for the commit path.
    always_comb begin
        data_all = {(PAGE_WORDS*WORD_W){1'b0}};
        for (int i = 0; i < PAGE_WORDS; i++) begin
            data_all[i*WORD_W +: WORD_W] = word_r[i];
        end
    end

endmodule

// File: rtl/prog_flash_ctrl_p.sv
// Parametrised program-flash controller: word-addressed array with an
// RWW/NRWW split, a 1-cycle instruction-fetch port and an SPM command port
// with cycle-counted page erase, page write and chip erase.
// Optional build macro: BOOT_LOCK_EN adds a boot_lock input that rejects
// page erase/write to the NRWW section while it is high.
module prog_flash_ctrl_p
    import prog_flash_pkg::*;
#(
    parameter int  WORD_W            = 16,
    parameter int  PAGE_WORDS        = 64,
    parameter int  NUM_PAGES         = 256,
    parameter int  NRWW_START_PAGE   = 224,
    parameter int  ERASE_CYCLES      = 16,
    parameter int  WRITE_CYCLES      = 16,
    parameter int  CHIP_ERASE_CYCLES = 64,
    localparam int AW                = $clog2(PAGE_WORDS*NUM_PAGES),
    localparam int PW                = $clog2(PAGE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              spm_req,
    input  logic [2:0]        spm_cmd,
    input  logic [AW-1:0]     spm_addr,
    input  logic [WORD_W-1:0] spm_data,
`ifdef BOOT_LOCK_EN
    input  logic              boot_lock,
`endif
    output logic              spm_ack,
    output logic              busy,
    output logic              rww_busy,
    output logic              err
);

    localparam int PGW = AW - PW;

    // Flash array; deliberately not reset, contents survive rst.
    logic [WORD_W-1:0] mem_r [PAGE_WORDS*NUM_PAGES];

    flash_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [PGW-1:0]    page_r, page_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              rww_busy_r, rww_nxt_s;
    logic              ack_r, ack_nxt_s;
    logic              err_r, err_nxt_s;
    logic [WORD_W-1:0] rd_data_r;
    logic              rd_valid_r;

    logic              fill_s;
    logic              commit_erase_s;
    logic              commit_write_s;
    logic              commit_chip_s;
    logic              lock_hit_s;
    logic [PGW-1:0]    spm_page_s;
    logic [PW-1:0]     spm_word_s;
    logic [PGW-1:0]    rd_page_s;
    logic [PAGE_WORDS*WORD_W-1:0] buf_data_s;

    assign spm_page_s = spm_addr[AW-1:PW];
    assign spm_word_s = spm_addr[PW-1:0];
    assign rd_page_s  = rd_addr[AW-1:PW];

`ifdef BOOT_LOCK_EN
    assign lock_hit_s = boot_lock && !in_rww(32'(spm_page_s), 32'(NRWW_START_PAGE));
`else
    assign lock_hit_s = 1'b0;
`endif

    // Buffer is emptied by reset and once a page write has been committed.
    prog_page_buffer #(
        .WORD_W     (WORD_W),
        .PAGE_WORDS (PAGE_WORDS)
    ) u_page_buffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (commit_write_s),
        .fill_en   (fill_s),
        .fill_idx  (spm_word_s),
        .fill_data (spm_data),
        .data_all  (buf_data_s)
    );

    // Next-state, countdown, flag and strobe logic for the SPM command FSM.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        page_nxt_s     = page_r;
        busy_nxt_s     = busy_r;
        rww_nxt_s      = rww_busy_r;
        ack_nxt_s      = 1'b0;
        err_nxt_s      = 1'b0;
        fill_s         = 1'b0;
        commit_erase_s = 1'b0;
        commit_write_s = 1'b0;
        commit_chip_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (spm_req) begin
                    case (spm_cmd_t'(spm_cmd))
                        BUF_FILL: begin
                            fill_s    = 1'b1;
                            ack_nxt_s = 1'b1;
                        end
                        PAGE_ERASE, PAGE_WRITE: begin
                            if (lock_hit_s) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                if (spm_cmd_t'(spm_cmd) == PAGE_ERASE) begin
                                    state_nxt_s = ERASE;
                                    cnt_nxt_s   = CNT_W'(ERASE_CYCLES - 1);
                                end else begin
                                    state_nxt_s = WRITE;
                                    cnt_nxt_s   = CNT_W'(WRITE_CYCLES - 1);
                                end
                                page_nxt_s = spm_page_s;
                                busy_nxt_s = 1'b1;
                                if (in_rww(32'(spm_page_s), 32'(NRWW_START_PAGE))) begin
                                    rww_nxt_s = 1'b1;
                                end else begin
                                    rww_nxt_s = rww_busy_r;
                                end
                            end
                        end
                        CHIP_ERASE: begin
                            state_nxt_s = CERASE;
                            cnt_nxt_s   = CNT_W'(CHIP_ERASE_CYCLES - 1);
                            busy_nxt_s  = 1'b1;
                            rww_nxt_s   = 1'b1;
                        end
                        RWW_EN: begin
                            rww_nxt_s = 1'b0;
                            ack_nxt_s = 1'b1;
                        end
                        default: begin
                            err_nxt_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ERASE, WRITE, CERASE: begin
                // Requests during an operation are refused without disturbing it.
                if (spm_req) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = 1'b0;
                end
                if (cnt_r == {CNT_W{1'b0}}) begin
                    if (state_r == ERASE) begin
                        commit_erase_s = 1'b1;
                    end else if (state_r == WRITE) begin
                        commit_write_s = 1'b1;
                    end else begin
                        commit_chip_s = 1'b1;
                    end
                    state_nxt_s = DONE;
                    busy_nxt_s  = 1'b0;
                    ack_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                // The completion ack owns this cycle; a new request is refused.
                if (spm_req) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = 1'b0;
                end
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Controller state and registered SPM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            page_r     <= {PGW{1'b0}};
            busy_r     <= 1'b0;
            rww_busy_r <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            page_r     <= page_nxt_s;
            busy_r     <= busy_nxt_s;
            rww_busy_r <= rww_nxt_s;
            ack_r      <= ack_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    // Array commit: chip erase, page erase or bit-clearing page program; reset aborts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (commit_chip_s) begin
                for (int i = 0; i < PAGE_WORDS*NUM_PAGES; i++) begin
                    mem_r[AW'(i)] <= {WORD_W{1'b1}};
                end
            end else if (commit_erase_s) begin
                for (int i = 0; i < PAGE_WORDS; i++) begin
                    mem_r[{page_r, PW'(i)}] <= {WORD_W{1'b1}};
                end
            end else if (commit_write_s) begin
                for (int i = 0; i < PAGE_WORDS; i++) begin
                    mem_r[{page_r, PW'(i)}] <= mem_r[{page_r, PW'(i)}] & buf_data_s[i*WORD_W +: WORD_W];
                end
            end
        end
    end

    // Fetch port: one-cycle latency; locked RWW reads return all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= {WORD_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (rd_en) begin
            rd_valid_r <= 1'b1;
            if (rww_busy_r && in_rww(32'(rd_page_s), 32'(NRWW_START_PAGE))) begin
                rd_data_r <= {WORD_W{1'b1}};
            end else begin
                rd_data_r <= mem_r[rd_addr];
            end
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign spm_ack  = ack_r;
    assign err      = err_r;
    assign busy     = busy_r;
    assign rww_busy = rww_busy_r;

endmodule

// File: doc/prog_flash_ctrl_p.md
Name: prog_flash_ctrl_p

Overview:
- Parametrised successor to the fixed ATmega328PB program-memory model.
- Word-addressed flash array with an RWW/NRWW split and a page buffer.
- Core instruction-fetch read port plus a self-programming (SPM) command port.
- Cycle-counted erase/write timing with busy flags.
- Sits between core PC/fetch logic and the flash array; the parallel-programming front end drives the SPM port.

Parameters:
- WORD_W, 16, flash word width in bits.
- PAGE_WORDS, 64, words per page (power of 2).
- NUM_PAGES, 256, pages in array (power of 2).
- NRWW_START_PAGE, 224, first page of NRWW section; pages below are RWW.
- ERASE_CYCLES, 16, clk cycles for page erase.
- WRITE_CYCLES, 16, clk cycles for page write.
- CHIP_ERASE_CYCLES, 64, clk cycles for chip erase.
- Derived (localparam): AW = log2(PAGE_WORDS*NUM_PAGES); PW = log2(PAGE_WORDS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  fetch request.
- rd_addr  in  AW  fetch word address (PC).
- rd_data  out  WORD_W  fetched word.
- rd_valid  out  1  rd_data valid.
- spm_req  in  1  command strobe, 1-cycle pulse.
- spm_cmd  in  3  command: BUF_FILL / PAGE_ERASE / PAGE_WRITE / RWW_EN / CHIP_ERASE.
- spm_addr  in  AW  word address; page = upper bits, word-in-page = low PW bits.
- spm_data  in  WORD_W  buffer-fill data.
- spm_ack  out  1  command accepted (1 cycle).
- busy  out  1  erase/write in progress.
- rww_busy  out  1  RWW section locked for reads.
- err  out  1  command rejected (1-cycle pulse).

Behaviour:
- Reset: all outputs 0; FSM to IDLE; page buffer set to all-ones with valid mask cleared; counter 0; rww_busy 0. Array contents are not reset.
- Read:
  - rd_en sampled at edge N; rd_data/rd_valid present at N+1 (1-cycle latency).
  - Reading an RWW address while rww_busy=1 gives rd_data='1 (all ones) with rd_valid=1.
  - NRWW reads are always served, even while busy.
- FSM states: IDLE, ERASE, WRITE, CERASE, DONE.
- IDLE, on spm_req:
  - BUF_FILL: store spm_data at buffer[word]; set mask bit; spm_ack. A second fill to the same word before write is ignored, but still acked (AVR rule).
  - PAGE_ERASE: latch page; -> ERASE; counter = ERASE_CYCLES-1; busy=1; rww_busy=1 if page < NRWW_START_PAGE.
  - PAGE_WRITE: same as PAGE_ERASE but -> WRITE with WRITE_CYCLES.
  - CHIP_ERASE: -> CERASE with CHIP_ERASE_CYCLES; rww_busy=1.
  - RWW_EN: clears rww_busy; ack. Only effective when busy=0; otherwise err.
  - Any other encoding: err, no ack.
- Any spm_req while busy=1: err=1, no ack, no state change.
- ERASE / WRITE / CERASE: decrement counter each cycle; at 0 commit and -> DONE.
  - ERASE commit: page words = '1.
  - WRITE commit: mem[page][i] &= buffer[i] (flash semantics: can only clear bits).
  - CERASE commit: entire array = '1.
- DONE: one cycle; spm_ack=1; busy=0. After WRITE, buffer reset to ones and mask cleared. -> IDLE.
- rww_busy stays 1 after completion until RWW_EN.
- Reset mid-operation: aborts with no commit, leaving the array unchanged; buffer cleared.
- spm_req and rd_en in the same cycle: both serviced independently.

Optional Feature:
- Macro: BOOT_LOCK_EN.
- Enabled: adds input boot_lock (1 bit). While boot_lock=1, PAGE_ERASE/PAGE_WRITE targeting a page >= NRWW_START_PAGE gives err=1, no ack, stay IDLE; CHIP_ERASE clears boot_lock's effect only externally and is always allowed.
- Disabled: no port; all pages writable.

Decomposition:
- Package prog_flash_pkg:
  - spm_cmd_t enum: BUF_FILL=3'd1, PAGE_ERASE=3'd3, PAGE_WRITE=3'd5, RWW_EN=3'd7, CHIP_ERASE=3'd2.
  - flash_state_t enum.
- Sub-module prog_page_buffer: PAGE_WORDS x WORD_W storage with valid mask, fill/clear/read-all.

Test Plan:
- Fill word 1 of page 1 with 16'h1234, PAGE_WRITE page 1 (addr 16'h0041) -> busy for 16 cycles, ack in DONE, read 16'h0041 returns 16'h1234, other words of page 1 return 16'hFFFF.
- Fill 16'h5678 twice (second fill 16'hAAAA) to same word, write -> reads 16'h5678.
- PAGE_ERASE RWW page 2 while fetching NRWW addr 14'h3800 (page 224, word 0, value 16'h6699) -> NRWW reads 16'h6699 every cycle; RWW reads 16'hFFFF until RWW_EN.
- spm_req PAGE_WRITE while busy -> err pulse, no ack, commit timing unchanged.
- Write 16'h0F0F over existing 16'h3333 without erase -> read 16'h0303.
- Assert rst at cycle 5 of a page erase -> page contents unchanged, busy=0, buffer empty. With BOOT_LOCK_EN and boot_lock=1, PAGE_WRITE to page 225 -> err, array unchanged.
